// File: rtl/store_commit_buffer.sv
// Store commit buffer: a circular FIFO of committed stores draining to memory.
// It merges stores into the youngest entry and flags loads that hit buffered words.
module store_commit_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] stAddr_i,
    input  logic [DATA_W-1:0] stData_i,
    input  logic [3:0]        stEn_i,
    output logic              stallStCommit_o,
    input  logic [ADDR_W-1:0] ldAddr_i,
    input  logic              ldEn_i,
    output logic              ldHazard_o,
    output logic [ADDR_W-1:0] memStAddr_o,
    output logic [DATA_W-1:0] memStData_o,
    output logic [3:0]        memStByteEn_o,
    output logic              memStValid_o,
    input  logic              memStAck_i,
    output logic              empty_o,
    output logic              overflow_o
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned LANE_W = DATA_W / 4;

    logic [ADDR_W-3:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [3:0]        be_q   [DEPTH];

    logic [PTR_W-1:0] head_q, tail_q, youngest;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q;

    logic st_req, full, deq, addr_match, merge, enq, drop;

    // Word-offset bits are intentionally ignored for matching.
    logic unused_byte_offsets;
    assign unused_byte_offsets = ^{stAddr_i[1:0], ldAddr_i[1:0]};

    assign st_req     = |stEn_i;
    assign full       = (count_q == CNT_W'(DEPTH));
    assign deq        = (count_q != '0) && memStAck_i;
    assign youngest   = tail_q - PTR_W'(1);
    assign addr_match = (addr_q[youngest] == stAddr_i[ADDR_W-1:2]);

    // Merge never targets the head: it needs two entries, three if the head pops now.
    assign merge = st_req && addr_match && (count_q >= CNT_W'(2)) &&
                   (!deq || (count_q >= CNT_W'(3)));
    assign enq   = st_req && !merge && !full;
    assign drop  = st_req && !merge && full;

    always_comb begin
        count_d = count_q;
        unique case ({enq, deq})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (enq) tail_q <= tail_q + PTR_W'(1);
            if (deq) head_q <= head_q + PTR_W'(1);
            if (drop) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            if (enq) begin
                addr_q[tail_q] <= stAddr_i[ADDR_W-1:2];
                data_q[tail_q] <= stData_i;
                be_q[tail_q]   <= stEn_i;
            end else if (merge) begin
                be_q[youngest] <= be_q[youngest] | stEn_i;
                for (int l = 0; l < 4; l++) begin
                    if (stEn_i[l]) begin
                        data_q[youngest][l*LANE_W +: LANE_W] <= stData_i[l*LANE_W +: LANE_W];
                    end
                end
            end
        end
    end

    always_comb begin
        logic [PTR_W-1:0] offset;
        ldHazard_o = 1'b0;
        offset     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = PTR_W'(i) - head_q;
            if ((CNT_W'(offset) < count_q) && (addr_q[i] == ldAddr_i[ADDR_W-1:2])) begin
                ldHazard_o = ldEn_i;
            end
        end
    end

    assign memStAddr_o     = {addr_q[head_q], 2'b00};
    assign memStData_o     = data_q[head_q];
    assign memStByteEn_o   = be_q[head_q];
    assign memStValid_o    = (count_q != '0);
    assign empty_o         = (count_q == '0);
    assign stallStCommit_o = full;
    assign overflow_o      = overflow_q;

endmodule

// File: tb/tb_store_commit_buffer.sv
// Directed bench for store_commit_buffer: enqueue, merge, full/overflow, hazards, reset.
module tb_store_commit_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] stAddr_i, stData_i, ldAddr_i;
    logic [3:0]  stEn_i;
    logic        ldEn_i, memStAck_i;
    logic        stallStCommit_o, ldHazard_o, memStValid_o, empty_o, overflow_o;
    logic [31:0] memStAddr_o, memStData_o;
    logic [3:0]  memStByteEn_o;

    int tests = 0;
    int fails = 0;

    store_commit_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .stAddr_i(stAddr_i), .stData_i(stData_i), .stEn_i(stEn_i),
        .stallStCommit_o(stallStCommit_o),
        .ldAddr_i(ldAddr_i), .ldEn_i(ldEn_i), .ldHazard_o(ldHazard_o),
        .memStAddr_o(memStAddr_o), .memStData_o(memStData_o),
        .memStByteEn_o(memStByteEn_o), .memStValid_o(memStValid_o),
        .memStAck_i(memStAck_i), .empty_o(empty_o), .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] en);
        stAddr_i = a; stData_i = d; stEn_i = en;
        step();
        stEn_i = 4'h0;
    endtask

    initial begin
        reset = 1'b1; stAddr_i = '0; stData_i = '0; stEn_i = '0;
        ldAddr_i = '0; ldEn_i = 1'b0; memStAck_i = 1'b0;
        step(); step();
        reset = 1'b0;
        #1;
        chk("rst_valid", memStValid_o, 0);
        chk("rst_stall", stallStCommit_o, 0);
        chk("rst_hazard", ldHazard_o, 0);
        chk("rst_empty", empty_o, 1);
        chk("rst_overflow", overflow_o, 0);

        // Single store, held while unacknowledged
        store(32'h100, 32'hAABBCCDD, 4'hF);
        chk("single_valid", memStValid_o, 1);
        chk("single_addr", memStAddr_o, 32'h100);
        chk("single_data", memStData_o, 32'hAABBCCDD);
        chk("single_be", memStByteEn_o, 4'hF);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("single_hold_addr", memStAddr_o, 32'h100);
            chk("single_hold_valid", memStValid_o, 1);
        end
        memStAck_i = 1'b1; step(); memStAck_i = 1'b0;
        chk("single_empty", empty_o, 1);
        chk("single_valid_off", memStValid_o, 0);

        // Merge into youngest only
        store(32'h200, 32'h00000011, 4'h1);
        store(32'h300, 32'h00000022, 4'h1);
        store(32'h300, 32'h0000EE00, 4'h2);
        chk("merge_count", dut.count_q, 2);
        chk("merge_head_addr", memStAddr_o, 32'h200);
        chk("merge_head_be", memStByteEn_o, 4'h1);
        memStAck_i = 1'b1; step(); memStAck_i = 1'b0;
        chk("merge_e1_addr", memStAddr_o, 32'h300);
        chk("merge_e1_be", memStByteEn_o, 4'h3);
        chk("merge_e1_data", memStData_o, 32'h0000EE22);
        memStAck_i = 1'b1; step(); memStAck_i = 1'b0;
        chk("merge_drained", empty_o, 1);

        // Head is never a merge target
        store(32'h500, 32'h000000A1, 4'h1);
        store(32'h500, 32'h0000B200, 4'h2);
        chk("nohead_count", dut.count_q, 2);
        chk("nohead_be", memStByteEn_o, 4'h1);
        memStAck_i = 1'b1; step(); step(); memStAck_i = 1'b0;
        chk("nohead_drained", empty_o, 1);

        // Fill and overflow
        store(32'h10, 32'hD1D1D1D1, 4'hF);
        store(32'h20, 32'hD2D2D2D2, 4'hF);
        store(32'h30, 32'hD3D3D3D3, 4'hF);
        chk("fill3_stall", stallStCommit_o, 0);
        store(32'h40, 32'hD4D4D4D4, 4'hF);
        chk("full_stall", stallStCommit_o, 1);
        store(32'h50, 32'hD5D5D5D5, 4'hF);
        chk("ovf_flag", overflow_o, 1);
        chk("ovf_count", dut.count_q, 4);
        chk("ovf_head", memStAddr_o, 32'h10);

        // Full with ack and store on the same edge: store dropped
        memStAck_i = 1'b1;
        store(32'h60, 32'hD6D6D6D6, 4'hF);
        chk("fullack_count", dut.count_q, 3);
        chk("fullack_head", memStAddr_o, 32'h20);
        chk("fullack_stall", stallStCommit_o, 0);
        store(32'h70, 32'hD7D7D7D7, 4'hF);
        chk("enqdeq_count", dut.count_q, 3);
        chk("enqdeq_head", memStAddr_o, 32'h30);
        step();
        chk("drain_head4", memStAddr_o, 32'h40);
        chk("drain_data4", memStData_o, 32'hD4D4D4D4);
        step();
        chk("drain_head7", memStAddr_o, 32'h70);
        chk("drain_data7", memStData_o, 32'hD7D7D7D7);
        step();
        memStAck_i = 1'b0;
        chk("drain_empty", empty_o, 1);
        chk("ovf_sticky", overflow_o, 1);

        // Ack while empty is ignored
        memStAck_i = 1'b1; step(); memStAck_i = 1'b0;
        chk("ack_empty_count", dut.count_q, 0);

        // Load hazard
        store(32'h400, 32'h00000077, 4'h1);
        ldEn_i = 1'b1; ldAddr_i = 32'h402; #1;
        chk("haz_same_word", ldHazard_o, 1);
        ldAddr_i = 32'h404; #1;
        chk("haz_next_word", ldHazard_o, 0);
        stAddr_i = 32'h404; stEn_i = 4'hF; #1;
        chk("haz_no_forward", ldHazard_o, 0);
        stEn_i = 4'h0;
        ldEn_i = 1'b0; ldAddr_i = 32'h400; #1;
        chk("haz_ld_disabled", ldHazard_o, 0);
        memStAck_i = 1'b1; step(); memStAck_i = 1'b0;
        ldEn_i = 1'b1; ldAddr_i = 32'h402; #1;
        chk("haz_after_ack", ldHazard_o, 0);
        ldEn_i = 1'b0;

        // Reset mid-drain
        store(32'h800, 32'h1, 4'hF);
        store(32'h900, 32'h2, 4'hF);
        store(32'hA00, 32'h3, 4'hF);
        chk("pre_rst_count", dut.count_q, 3);
        reset = 1'b1; step(); reset = 1'b0;
        chk("mid_rst_empty", empty_o, 1);
        chk("mid_rst_valid", memStValid_o, 0);
        chk("mid_rst_overflow", overflow_o, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/store_commit_buffer.md
STORE_COMMIT_BUFFER -- requirements
Module: store_commit_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of buffered committed stores (power of two, at least 2).
REQ-002 SHALL have parameter ADDR_W, default 32: store address width.
REQ-003 SHALL have parameter DATA_W, default 32: store data width (4 byte lanes).
REQ-004 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-005 Port: reset  in  1  synchronous, active-high reset.
REQ-006 Port: stAddr_i  in  ADDR_W  committed store address from the LSU.
REQ-007 Port: stData_i  in  DATA_W  committed store data, lane-aligned.
REQ-008 Port: stEn_i  in  4  committed store byte enables; nonzero means a store is presented this cycle.
REQ-009 Port: stallStCommit_o  out  1  buffer cannot accept a store; the LSU holds store commit.
REQ-010 Port: ldAddr_i  in  ADDR_W  load address from the LSU.
REQ-011 Port: ldEn_i  in  1  load request valid.
REQ-012 Port: ldHazard_o  out  1  the load word matches a buffered store; the load is replayed.
REQ-013 Port: memStAddr_o  out  ADDR_W  head entry word address, with bits [1:0] = 0.
REQ-014 Port: memStData_o  out  DATA_W  head entry data.
REQ-015 Port: memStByteEn_o  out  4  head entry byte enables.
REQ-016 Port: memStValid_o  out  1  memory write request valid.
REQ-017 Port: memStAck_i  in  1  memory accepted the head write this cycle.
REQ-018 Port: empty_o  out  1  no entries buffered.
REQ-019 Port: overflow_o  out  1  sticky error flag: a store arrived while full and was dropped.

Function
REQ-020 SHALL be a circular FIFO of DEPTH entries, each holding {word address, data, byteEn}, indexed by head/tail pointers of log2(DEPTH) bits.
REQ-021 SHALL keep a count of log2(DEPTH)+1 bits; pointers wrap modulo DEPTH.
REQ-022 Enqueue SHALL write the tail entry and advance the tail on the clock edge when stEn_i != 0, no stall condition holds, and merge (REQ-025) is not taken.
REQ-023 An enqueued store SHALL be visible on the memory outputs no earlier than the next cycle; minimum enqueue-to-memStValid_o latency is 1 cycle.
REQ-024 memStValid_o SHALL equal (count != 0); memStAddr_o, memStData_o and memStByteEn_o SHALL stay stable while memStValid_o=1 and memStAck_i=0.
REQ-025 Merge: when count >= 2 and stAddr_i word matches the youngest entry (tail-1), SHALL OR stEn_i into that entry's byteEn and overwrite only the enabled lanes of its data; tail and count SHALL NOT change.
REQ-026 Merge SHALL NOT target the head entry, even when count = 1, because the head is under an outstanding request.
REQ-027 Dequeue SHALL advance the head and decrement count on any edge where memStValid_o=1 and memStAck_i=1.
REQ-028 memStAck_i while count = 0 SHALL be ignored.
REQ-029 Simultaneous enqueue and dequeue SHALL leave count unchanged and move both pointers.
REQ-030 Simultaneous merge and dequeue SHALL be legal only when count >= 3 at that edge, so the merge target is never the entry being popped; with count = 2 a matching store SHALL enqueue instead.
REQ-031 stallStCommit_o SHALL equal (count == DEPTH), combinationally; it SHALL NOT depend on memStAck_i.
REQ-032 If stEn_i != 0 while count == DEPTH and the store cannot merge, the store SHALL be dropped and overflow_o set; overflow_o SHALL hold until reset.
REQ-033 ldHazard_o SHALL be combinational: ldEn_i AND some valid entry has address[ADDR_W-1:2] == ldAddr_i[ADDR_W-1:2]; byte overlap is not checked.
REQ-034 ldHazard_o SHALL NOT consider a store presented on stAddr_i in the same cycle.
REQ-035 empty_o SHALL equal (count == 0).
REQ-036 The buffer holds only committed stores; there is no flush or recovery input, and contents always drain.

Reset
REQ-037 While reset=1 at a clock edge: head, tail and count SHALL be 0 and overflow_o SHALL be 0.
REQ-038 After reset: memStValid_o=0, stallStCommit_o=0, ldHazard_o=0, empty_o=1.
REQ-039 Entry contents need not be reset; memory data outputs are don't-care while memStValid_o=0.
REQ-040 Reset asserted mid-operation SHALL discard all entries, including an unacknowledged head; memStValid_o SHALL be 0 the cycle after.

Verification
REQ-041 Single store: stAddr_i=0x100, data 0xAABBCCDD, stEn_i=0xF, memStAck_i=0 -> next cycle memStValid_o=1 and addr 0x100; outputs held 3 cycles; ack -> empty_o=1 the following cycle.
REQ-042 Merge: memStAck_i=0; stores 0x200/en 0x1, then 0x300/en 0x1, then 0x300/en 0x2 with data 0x0000EE00 -> count=2; entry 0x300 byteEn 0x3 with byte1=0xEE; 0x200 never merges.
REQ-043 Full and overflow: 4 distinct stores, no ack -> stallStCommit_o=1; 5th distinct store -> dropped, overflow_o=1, count stays 4.
REQ-044 Full with simultaneous events: at full, ack on the same edge a new store arrives while stall_o=1 -> store dropped, count=3; on the next edge a store plus ack -> count stays 3 and pointers wrap through index 0.
REQ-045 Load hazard: buffered 0x400 with en 0x1; ldAddr_i=0x402, ldEn_i=1 -> ldHazard_o=1; ldAddr_i=0x404 -> 0; after 0x400 is acknowledged -> 0.
REQ-046 Reset mid-drain: 3 entries with the head unacknowledged, reset pulse -> empty_o=1, memStValid_o=0, overflow_o=0 next cycle.
